// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver: FSM state encoding,
// legal oversampling ratios and parity type encodings.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } rx_state_t;

    localparam int unsigned PS_8       = 8;
    localparam int unsigned PS_16      = 16;
    localparam int unsigned PS_32      = 32;
    localparam int unsigned PS_DEFAULT = PS_8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic is_legal_prescale(input int unsigned p);
        return (p == PS_8) || (p == PS_16) || (p == PS_32);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-period timing for the UART receiver: edge counter, three mid-bit samples
// and a 2-of-3 majority vote presented the cycle after the last sample.
module uart_rx_sampler #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_run,
    input  logic                  i_rx,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic                  o_sampled_bit,
    output logic                  o_sample_valid,
    output logic                  o_bit_end
);

    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [2:0]            r_samples;
    logic                  r_sample_valid;

    logic [PRESCALE_W-1:0] w_mid;
    logic [PRESCALE_W-1:0] w_mid_m1;
    logic [PRESCALE_W-1:0] w_mid_p1;
    logic [PRESCALE_W-1:0] w_last;
    logic                  w_bit_end;

    assign w_mid     = i_prescale >> 1;
    assign w_mid_m1  = w_mid - PRESCALE_W'(1);
    assign w_mid_p1  = w_mid + PRESCALE_W'(1);
    assign w_last    = i_prescale - PRESCALE_W'(1);
    assign w_bit_end = i_run && (r_edge_cnt == w_last);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_edge_cnt     <= '0;
            r_samples      <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            // Counter is parked at zero outside a frame so START begins at 0.
            if (!i_run || w_bit_end) begin
                r_edge_cnt <= '0;
            end else begin
                r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
            end

            if (i_run && (r_edge_cnt == w_mid_m1)) r_samples[0] <= i_rx;
            if (i_run && (r_edge_cnt == w_mid))    r_samples[1] <= i_rx;
            if (i_run && (r_edge_cnt == w_mid_p1)) r_samples[2] <= i_rx;

            r_sample_valid <= i_run && (r_edge_cnt == w_mid_p1);
        end
    end

    assign o_sampled_bit  = (r_samples[0] & r_samples[1]) |
                            (r_samples[0] & r_samples[2]) |
                            (r_samples[1] & r_samples[2]);
    assign o_sample_valid = r_sample_valid;
    assign o_bit_end      = w_bit_end;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detect, LSB-first data, optional parity, one stop bit.
// Optional macro UART_RX_SYNC_EN adds a two-flop input synchronizer on RX_IN.
//
// state  | meaning
// IDLE   | line idle, waiting for RX_IN low
// START  | validating start bit, glitch returns to IDLE
// DATA   | shifting in DATA_WIDTH bits
// PARITY | checking parity bit
// STOP   | sampling stop bit, leaves right after the mid-bit vote
// DONE   | one-cycle result: data_valid or error pulses
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int BC_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_WIDTH - 1);

    rx_state_t r_state;
    rx_state_t w_next;

    logic [BC_W-1:0]       r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic [PRESCALE_W-1:0] r_prescale;
    logic                  r_par_bad;
    logic                  r_data_valid;
    logic                  r_par_err;
    logic                  r_stp_err;

    logic                  w_rx;
    logic                  w_run;
    logic                  w_bit;
    logic                  w_sample_valid;
    logic                  w_bit_end;
    logic                  w_par_exp;
    logic [PRESCALE_W-1:0] w_ps_legal;

`ifdef UART_RX_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], RX_IN};
        end
    end

    assign w_rx = r_sync[1];
`else
    assign w_rx = RX_IN;
`endif

    assign w_ps_legal = is_legal_prescale(32'(Prescale)) ? Prescale
                                                         : PRESCALE_W'(PS_DEFAULT);
    assign w_run      = (r_state == START) || (r_state == DATA) ||
                        (r_state == PARITY) || (r_state == STOP);
    assign w_par_exp  = (^r_shift) ^ (r_par_typ == PAR_ODD);

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .i_clk          (CLK),
        .i_rst          (RST),
        .i_run          (w_run),
        .i_rx           (w_rx),
        .i_prescale     (r_prescale),
        .o_sampled_bit  (w_bit),
        .o_sample_valid (w_sample_valid),
        .o_bit_end      (w_bit_end)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (!w_rx) w_next = START;
            end
            START: begin
                if (w_sample_valid && w_bit) begin
                    w_next = IDLE;
                end else if (w_bit_end) begin
                    w_next = DATA;
                end
            end
            DATA: begin
                if (w_bit_end && (r_bit_cnt == LAST_BIT)) begin
                    w_next = r_par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (w_bit_end) w_next = STOP;
            end
            STOP: begin
                if (w_sample_valid) w_next = DONE;
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_par_en     <= 1'b0;
            r_par_typ    <= PAR_EVEN;
            r_prescale   <= PRESCALE_W'(PS_DEFAULT);
            r_par_bad    <= 1'b0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rx) begin
                        r_par_en   <= PAR_EN;
                        r_par_typ  <= PAR_TYP;
                        r_prescale <= w_ps_legal;
                        r_par_bad  <= 1'b0;
                        r_bit_cnt  <= '0;
                    end
                end
                DATA: begin
                    if (w_sample_valid) begin
                        r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
                    end
                    if (w_bit_end) begin
                        r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + BC_W'(1);
                    end
                end
                PARITY: begin
                    if (w_sample_valid) r_par_bad <= (w_bit != w_par_exp);
                end
                STOP: begin
                    // Results are registered here so they are visible during DONE.
                    if (w_sample_valid) begin
                        if (!r_par_bad && w_bit) begin
                            r_data_valid <= 1'b1;
                            r_data       <= r_shift;
                        end
                        r_par_err <= r_par_bad;
                        r_stp_err <= !w_bit;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign P_DATA     = r_data;
    assign data_valid = r_data_valid;
    assign par_err    = r_par_err;
    assign stp_err    = r_stp_err;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// compared against a frame-level reference model with exact result timing.
module tb_uart_rx;

    logic       CLK      = 1'b0;
    logic       RST      = 1'b1;
    logic       RX_IN    = 1'b1;
    logic       PAR_EN   = 1'b0;
    logic       PAR_TYP  = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;

`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    typedef struct {
        int         cyc;
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] d;
    } ev_t;

    ev_t        ev_q[$];
    int         total     = 0;
    int         bad       = 0;
    int         cyc       = 0;
    int         last_done = -100000;
    logic [7:0] model_data = 8'h00;

    uart_rx #(
        .DATA_WIDTH (8),
        .PRESCALE_W (6)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (!RST && (data_valid || par_err || stp_err)) begin
            ev_q.push_back('{cyc, data_valid, par_err, stp_err, P_DATA});
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int eff_p(input logic [5:0] ps);
        return (ps == 6'd8 || ps == 6'd16 || ps == 6'd32) ? int'(ps) : 8;
    endfunction

    // All drive tasks start and end just after a rising edge.
    task automatic drive_bit(input logic b, input int n);
        RX_IN = b;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        drive_bit(1'b1, n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                              input logic [5:0] ps, input logic flip, input logic stp,
                              output int ts);
        int p;
        p        = eff_p(ps);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        Prescale = ps;
        ts       = cyc;
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) begin
            // Config must have been captured at frame start; scramble it now.
            PAR_EN   = 1'($urandom);
            PAR_TYP  = 1'($urandom);
            Prescale = 6'($urandom);
            drive_bit(d[i], p);
            if (i == 3) chk("busy_mid", busy, 1);
        end
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        Prescale = ps;
        if (pen) drive_bit((^d) ^ ptyp ^ flip, p);
        drive_bit(stp, p);
        RX_IN = 1'b1;
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic pen, input logic flip,
                                input logic stp, input int p, input int ts);
        int   det;
        int   ec;
        logic xdv;
        logic xpe;
        logic xse;
        ev_t  e;
        det = ts + 1 + SYNC_LAT;
        if (last_done + 2 > det) det = last_done + 2;
        ec  = det + (10 + int'(pen)) * p - p / 2 + 3;
        xpe = pen & flip;
        xse = ~stp;
        xdv = ~xpe & stp;
        if (xdv) model_data = d;
        chk("ev_present", ev_q.size() > 0, 1);
        if (ev_q.size() > 0) begin
            e = ev_q.pop_front();
            chk("ev_cycle", e.cyc, ec);
            chk("ev_valid", e.dv, xdv);
            chk("ev_par_err", e.pe, xpe);
            chk("ev_stp_err", e.se, xse);
            chk("ev_pdata", e.d, model_data);
        end
        last_done = ec;
    endtask

    task automatic run_one(input logic [7:0] d, input logic pen, input logic ptyp,
                           input logic [5:0] ps, input logic flip, input logic stp);
        int ts;
        send_frame(d, pen, ptyp, ps, flip, stp, ts);
        idle(3 * eff_p(ps));
        expect_frame(d, pen, flip, stp, eff_p(ps), ts);
        chk("no_extra_ev", ev_q.size(), 0);
        chk("pdata_hold", P_DATA, model_data);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int         t1;
        int         t2;
        logic [5:0] ps;
        logic [7:0] d;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_pdata", P_DATA, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_par_err", par_err, 0);
        chk("rst_stp_err", stp_err, 0);
        chk("rst_busy", busy, 0);
        RST = 1'b0;
        idle(4);

        run_one(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0, 1'b1);
        run_one(8'h3C, 1'b1, 1'b0, 6'd16, 1'b0, 1'b1);
        run_one(8'h3C, 1'b1, 1'b0, 6'd16, 1'b1, 1'b1);
        run_one(8'h01, 1'b1, 1'b1, 6'd32, 1'b0, 1'b0);

        // Two-cycle glitch must be rejected silently.
        Prescale = 6'd16;
        PAR_EN   = 1'b0;
        drive_bit(1'b0, 2);
        idle(2);
        chk("glitch_busy_hi", busy, 1);
        idle(32);
        chk("glitch_busy_lo", busy, 0);
        chk("glitch_no_ev", ev_q.size(), 0);
        chk("glitch_pdata", P_DATA, model_data);

        send_frame(8'h55, 1'b0, 1'b0, 6'd8, 1'b0, 1'b1, t1);
        send_frame(8'hFF, 1'b0, 1'b0, 6'd8, 1'b0, 1'b1, t2);
        idle(24);
        expect_frame(8'h55, 1'b0, 1'b0, 1'b1, 8, t1);
        expect_frame(8'hFF, 1'b0, 1'b0, 1'b1, 8, t2);
        chk("b2b_no_extra", ev_q.size(), 0);
        chk("b2b_pdata", P_DATA, 8'hFF);

        // Reset in the middle of the data bits of 0x7E.
        Prescale = 6'd16;
        PAR_EN   = 1'b0;
        d        = 8'h7E;
        drive_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) drive_bit(d[i], 16);
        RX_IN = 1'b1;
        RST   = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("mid_rst_pdata", P_DATA, 0);
        chk("mid_rst_valid", data_valid, 0);
        chk("mid_rst_par_err", par_err, 0);
        chk("mid_rst_stp_err", stp_err, 0);
        chk("mid_rst_busy", busy, 0);
        RST        = 1'b0;
        model_data = 8'h00;
        ev_q.delete();
        idle(4);
        run_one(8'h81, 1'b0, 1'b0, 6'd16, 1'b0, 1'b1);

        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 3))
                0:       ps = 6'd8;
                1:       ps = 6'd16;
                2:       ps = 6'd32;
                default: begin
                    ps = 6'($urandom);
                    while (ps == 6'd8 || ps == 6'd16 || ps == 6'd32) ps = 6'($urandom);
                end
            endcase
            run_one(8'($urandom), 1'($urandom), 1'($urandom), ps,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver; the receive-side counterpart of the UART transmitter in the UART subsystem.
- Oversamples serial line RX_IN at a configurable prescale and detects start bits.
- Recovers DATA_WIDTH data bits LSB-first, with an optional parity bit and one stop bit.
- Presents the parallel word with a one-cycle valid pulse and error flags to the system controller / RX FIFO.

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESCALE_W, 6, width of Prescale input (oversampling ratio up to 32)

Ports:
CLK  in  1  system clock (one clock domain)
RST  in  1  reset; synchronous, active-high
RX_IN  in  1  serial line, idle high
PAR_EN  in  1  1 = frame carries a parity bit
PAR_TYP  in  1  0 = even, 1 = odd parity
Prescale  in  PRESCALE_W  oversampling ratio; legal values 8, 16, 32
P_DATA  out  DATA_WIDTH  received word; holds last good value
data_valid  out  1  one-cycle pulse, P_DATA updated and frame error-free
par_err  out  1  one-cycle pulse, parity mismatch
stp_err  out  1  one-cycle pulse, stop bit sampled low
busy  out  1  high while a frame is being received

Behaviour:
- Reset (RST high at CLK edge):
  - All outputs go to 0; P_DATA goes to 0.
  - FSM goes to IDLE and counters clear; any frame in progress is abandoned.
- Configuration capture: PAR_EN, PAR_TYP and Prescale are latched on the IDLE->START transition and held constant for the whole frame.
- Illegal Prescale value (not 8/16/32): treated as 8.
- Counters:
  - edge_cnt runs 0..P-1 within each bit period (P = latched prescale).
  - bit_cnt counts 0..DATA_WIDTH-1 in DATA state.
- Sampling: RX_IN is sampled at edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the 2-of-3 majority, valid at the cycle after edge_cnt = P/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE:
  - busy=0.
  - RX_IN==0 -> START, with edge_cnt=0 in that cycle.
- START:
  - Majority bit 1 = glitch: return to IDLE with no flags raised.
  - Otherwise, at edge_cnt = P-1 -> DATA.
- DATA:
  - Majority bit is shifted into the shift register at the MSB, giving LSB-first assembly.
  - At edge_cnt = P-1 with bit_cnt = DATA_WIDTH-1 -> PARITY if PAR_EN, else STOP.
- PARITY:
  - Expected value = XOR of data bits (even), or its inverse (odd).
  - The mismatch result is stored.
  - At edge_cnt = P-1 -> STOP.
- STOP: after the majority sample, go to DONE immediately. The state does not wait for the end of the bit, which tolerates clock mismatch and allows back-to-back frames.
- DONE (one cycle):
  - If parity OK and stop==1: data_valid=1 and P_DATA <= shift register.
  - Otherwise P_DATA is unchanged; par_err and/or stp_err pulse. Both may pulse together.
  - Next state is IDLE.
- busy: 1 in START through DONE.
- Simultaneous events: the start bit of the next frame may begin during DONE or the remaining half of the stop bit; IDLE detects the low level in the following cycle.
- Latency: data_valid asserts (10+PAR_EN)·P - P/2 + 3 cycles after the falling RX_IN edge is first seen in IDLE, ±1 cycle for the start-detect cycle. The bench checks the exact value against the RTL.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined: RX_IN passes through a two-flop synchronizer, reset to 1, before the FSM and sampler. All latencies grow by 2 cycles.
- Undefined: RX_IN is used directly; the integrator guarantees it is already synchronous to CLK.

Decomposition:
- Package uart_rx_pkg:
  - rx_state_t enum: IDLE, START, DATA, PARITY, STOP, DONE.
  - Constants for legal prescale values (8, 16, 32) and the default prescale (8).
  - Parity type encodings: EVEN=0, ODD=1.
- Sub-module uart_rx_sampler:
  - Contains edge_cnt, the three-sample capture and the majority vote.
  - Outputs sampled_bit, sample_valid and bit_end (edge_cnt = P-1).
  - The FSM, shift register and parity/stop checks stay in uart_rx.

Test Plan:
- Prescale=8, PAR_EN=0, frame 0xA5: one data_valid pulse, P_DATA=0xA5, no error flags, busy high for the frame.
- Prescale=16, PAR_EN=1, PAR_TYP=0, 0x3C with parity bit 0: data_valid, P_DATA=0x3C. Repeat with parity bit forced 1: par_err pulses, data_valid=0, P_DATA stays 0x3C.
- Prescale=32, PAR_EN=1, PAR_TYP=1, 0x01 with stop bit driven 0: stp_err pulses, no data_valid.
- RX_IN low pulse of 2 cycles at Prescale=16: FSM returns to IDLE, busy drops, no flags, P_DATA unchanged.
- Back-to-back frames 0x55 then 0xFF with zero idle bits at Prescale=8: two data_valid pulses with the correct words in order.
- RST asserted mid-DATA of 0x7E, then a clean 0x81 frame: all outputs 0 after reset, then a single data_valid with P_DATA=0x81.
